// File: rtl/map_scheduler.sv
// rtl/map_scheduler.sv - block_generator sequencer with a DEPTH-row circular map buffer
// Optional init watchdog: define MAP_SCHED_WATCHDOG_EN.
module map_scheduler #(
  parameter int DEPTH        = 8,
  parameter int GEN_LATENCY  = 2,
  parameter int INIT_TIMEOUT = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     scroll_req,
  output logic                     scroll_ack,
  output logic                     generate_map,
  input  logic [6:0]               gen_layer_map,
  input  logic [6:0]               gen_block_type,
  input  logic [6:0]               gen_bonus_map,
  input  logic                     gen_load_layer,
  input  logic                     gen_map_ready,
  input  logic [$clog2(DEPTH)-1:0] rd_index,
  output logic [6:0]               rd_layer_map,
  output logic [6:0]               rd_block_type,
  output logic [6:0]               rd_bonus_map,
  output logic                     map_valid,
  output logic                     busy,
  output logic                     err
);
  localparam int AW = $clog2(DEPTH);
  localparam int WW = (GEN_LATENCY > 1) ? $clog2(GEN_LATENCY) : 1;
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_INIT_REQ  = 3'd1;
  localparam logic [2:0] S_INIT_FILL = 3'd2;
  localparam logic [2:0] S_TOPUP     = 3'd3;
  localparam logic [2:0] S_GEN_REQ   = 3'd4;
  localparam logic [2:0] S_GEN_WAIT  = 3'd5;
  localparam logic [2:0] S_READY     = 3'd6;
  localparam logic [2:0] S_ERR       = 3'd7;

  logic [2:0]    state;
  logic [AW-1:0] base;
  logic [AW:0]   count;
  logic [WW-1:0] wait_cnt;
  logic [20:0]   mem [DEPTH];
  logic [20:0]   rd_data;
  logic [20:0]   wr_data;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr;
  logic          wr_en;
  logic          wd_fire;

  assign wr_addr = base + count[AW-1:0];
  assign rd_addr = base + rd_index;
  assign wr_data = {gen_layer_map, gen_block_type, gen_bonus_map};
  assign wr_en   = ((state == S_INIT_FILL) && gen_load_layer) ||
                   ((state == S_GEN_WAIT) && (wait_cnt == '0));

  assign generate_map = (state == S_INIT_REQ) || (state == S_GEN_REQ);
  assign scroll_ack   = (state == S_READY) && scroll_req;
  assign map_valid    = (count == FULL);
  assign busy         = (state != S_IDLE) && (state != S_READY);

  assign rd_layer_map  = rd_data[20:14];
  assign rd_block_type = rd_data[13:7];
  assign rd_bonus_map  = rd_data[6:0];

`ifdef MAP_SCHED_WATCHDOG_EN
  localparam int TW = $clog2(INIT_TIMEOUT + 1);
  logic [TW-1:0] wd_cnt;

  // Counts cycles since the init generate_map pulse; frozen once the first row lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt <= '0;
    end else if (state == S_INIT_REQ) begin
      wd_cnt <= TW'(1);
    end else if ((state == S_INIT_FILL) && (count == '0)) begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end

  assign wd_fire = (state == S_INIT_FILL) && (count == '0) && !gen_load_layer &&
                   (wd_cnt == TW'(INIT_TIMEOUT - 1));
  assign err     = (state == S_ERR);
`else
  assign wd_fire = 1'b0;
  assign err     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      base     <= '0;
      count    <= '0;
      wait_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) state <= S_INIT_REQ;
        S_INIT_REQ: begin
          base  <= '0;
          count <= '0;
          state <= S_INIT_FILL;
        end
        S_INIT_FILL: begin
          if (gen_load_layer) count <= count + 1'b1;
          if (wd_fire) state <= S_ERR;
          else if (gen_map_ready) state <= S_TOPUP;
        end
        S_TOPUP: state <= map_valid ? S_READY : S_GEN_REQ;
        S_GEN_REQ: begin
          wait_cnt <= WW'(GEN_LATENCY - 1);
          state    <= S_GEN_WAIT;
        end
        S_GEN_WAIT: begin
          if (wait_cnt == '0) begin
            count <= count + 1'b1;
            state <= S_TOPUP;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        S_READY: begin
          if (scroll_req) begin
            base  <= base + 1'b1;
            count <= count - 1'b1;
            state <= S_TOPUP;
          end
        end
        default: state <= state;
      endcase
    end
  end

  // Read samples the array before this edge's write, so same-address collisions return old data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_data <= '0;
    end else begin
      if (wr_en) mem[wr_addr] <= wr_data;
      rd_data <= mem[rd_addr];
    end
  end
endmodule

// File: tb/tb_map_scheduler.sv
// tb/tb_map_scheduler.sv - scoreboard bench for map_scheduler
module tb_map_scheduler;
  localparam int DEPTH        = 8;
  localparam int GEN_LATENCY  = 2;
  localparam int INIT_TIMEOUT = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       scroll_req = 1'b0;
  logic       gen_load_layer = 1'b0;
  logic       gen_map_ready = 1'b0;
  logic [6:0] gen_layer_map = '0;
  logic [6:0] gen_block_type = '0;
  logic [6:0] gen_bonus_map = '0;
  logic [2:0] rd_index = '0;
  logic       scroll_ack, generate_map, map_valid, busy, err;
  logic [6:0] rd_layer_map, rd_block_type, rd_bonus_map;

  map_scheduler #(.DEPTH(DEPTH), .GEN_LATENCY(GEN_LATENCY), .INIT_TIMEOUT(INIT_TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .scroll_req(scroll_req), .scroll_ack(scroll_ack),
    .generate_map(generate_map), .gen_layer_map(gen_layer_map), .gen_block_type(gen_block_type),
    .gen_bonus_map(gen_bonus_map), .gen_load_layer(gen_load_layer), .gen_map_ready(gen_map_ready),
    .rd_index(rd_index), .rd_layer_map(rd_layer_map), .rd_block_type(rd_block_type),
    .rd_bonus_map(rd_bonus_map), .map_valid(map_valid), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic v; logic [20:0] d;} exp_t;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  logic [20:0] model[$];
  exp_t expq[$];
  logic [20:0] init_rows [4] = '{21'h10A0A1, 21'h0B0B0B, 21'h1C0C0C, 21'h0D0D0D};
  bit   init_pending = 0, gen_silent = 0, init_now = 0, prev_valid = 0;
  int   init_base = -1, refill_due = -1, gm_count = 0, init_gm_cyc = -1;
  int   ack_count = 0, ack_cyc = -1, valid_rise_cyc = -1;
  logic [20:0] next_row = '0, last_refill = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [20:0] rd_word();
    return {rd_layer_map, rd_block_type, rd_bonus_map};
  endfunction

  // Generator model: init rows on gen_load_layer, refill row valid only GEN_LATENCY after the pulse.
  task automatic gen_step();
    logic [20:0] row;
    row = 21'($urandom);
    gen_load_layer = 1'b0;
    gen_map_ready  = 1'b0;
    init_now       = 0;
    if (init_base >= 0 && cyc >= init_base && cyc < init_base + 4) begin
      row            = init_rows[cyc - init_base];
      gen_load_layer = 1'b1;
      gen_map_ready  = (cyc == init_base + 3);
      init_now       = 1;
    end
    if (refill_due == cyc) row = next_row;
    {gen_layer_map, gen_block_type, gen_bonus_map} = row;
  endtask

  task automatic monitor();
    exp_t e;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      if (e.v) check("rd_data", rd_word(), e.d);
    end
    e.v = (int'(rd_index) < model.size());
    e.d = e.v ? model[rd_index] : '0;
    expq.push_back(e);
    check("map_valid", map_valid, model.size() == DEPTH);
    if (map_valid && !prev_valid) valid_rise_cyc = cyc;
    prev_valid = map_valid;
    if (scroll_ack) begin
      ack_count++;
      ack_cyc = cyc;
      check("ack_only_in_ready", {busy, map_valid}, 2'b01);
      if (model.size() > 0) model.delete(0);
    end
    if (generate_map) begin
      gm_count++;
      if (init_pending) begin
        init_pending = 0;
        init_gm_cyc  = cyc;
        if (!gen_silent) init_base = cyc + 2;
      end else begin
        refill_due = cyc + GEN_LATENCY;
        next_row   = 21'($urandom);
      end
    end
    if (init_now) model.push_back(init_rows[cyc - init_base]);
    if (refill_due == cyc) begin
      model.push_back(next_row);
      last_refill = next_row;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    cyc++;
    gen_step();
  endtask

  task automatic wait_ready(input int budget);
    int n;
    n = 0;
    while (!(map_valid && !busy) && n < budget) begin
      tick();
      n++;
    end
    check("wait_ready", {busy, map_valid}, 2'b01);
  endtask

  task automatic sweep();
    for (int i = 0; i < DEPTH; i++) begin
      rd_index = 3'(i);
      tick();
    end
    tick();
  endtask

  task automatic flush_model();
    model.delete();
    expq.delete();
    init_base    = -1;
    refill_due   = -1;
    init_pending = 0;
    prev_valid   = 0;
  endtask

  task automatic do_init();
    int gm0, t0;
    gm0 = gm_count;
    t0 = cyc;
    init_pending = 1;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_ready(200);
    check("init_req_cycle", init_gm_cyc - t0, 1);
    check("init_gen_pulses", gm_count - gm0, 5);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int g0, a0, n;
    #3;
    check("reset_outputs", {generate_map, scroll_ack, map_valid, busy, err, rd_word()}, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    do_init();
    for (int k = 0; k < 4; k++) begin
      rd_index = 3'(k);
      tick();
      check("init_row", rd_word(), init_rows[k]);
    end
    sweep();

    wait_ready(50);
    g0 = gm_count;
    a0 = ack_count;
    scroll_req = 1'b1;
    tick();
    scroll_req = 1'b0;
    check("scroll_ack_same_cycle", ack_count - a0, 1);
    rd_index = 3'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("scroll_bottom_is_B", rd_word(), init_rows[1]);
    wait_ready(50);
    check("scroll_one_refill", gm_count - g0, 1);
    check("scroll_refill_time", valid_rise_cyc - ack_cyc, 3 + GEN_LATENCY);
    rd_index = 3'd7;
    tick();
    check("refill_at_top", rd_word(), last_refill);
    sweep();

    wait_ready(50);
    gen_load_layer = 1'b1;
    {gen_layer_map, gen_block_type, gen_bonus_map} = 21'h155555;
    tick();
    check("stray_load_ignored", {busy, map_valid}, 2'b01);
    sweep();

    wait_ready(50);
    a0 = ack_count;
    n = 0;
    scroll_req = 1'b1;
    while ((ack_count - a0) < 20 && n < 400) begin
      tick();
      n++;
    end
    scroll_req = 1'b0;
    wait_ready(50);
    check("wrap_acks", ack_count - a0, 20);
    sweep();

    wait_ready(50);
    scroll_req = 1'b1;
    tick();
    scroll_req = 1'b0;
    tick();
    tick();
    check("in_gen_wait", {busy, map_valid}, 2'b10);
    #2;
    rst_n = 1'b0;
    flush_model();
    #1;
    check("async_reset_outputs", {generate_map, scroll_ack, map_valid, busy, err, rd_word()}, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("reset_rd_zero", rd_word(), 0);
    do_init();
    sweep();

    rst_n = 1'b0;
    flush_model();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    gen_silent = 1;
    init_pending = 1;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("wd_init_pulse", generate_map, 1);
    for (int k = 1; k <= INIT_TIMEOUT + 4; k++) begin
      tick();
`ifdef MAP_SCHED_WATCHDOG_EN
      if (k == INIT_TIMEOUT - 1) check("wd_before_timeout", err, 0);
      if (k == INIT_TIMEOUT) check("wd_fire", {err, busy}, 2'b11);
`else
      check("wd_absent_err", err, 0);
`endif
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
`ifdef MAP_SCHED_WATCHDOG_EN
    check("wd_held", {err, busy}, 2'b11);
`else
    check("wd_absent_waiting", {err, busy}, 2'b01);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
